hex_scroll_display: RTL

//   Scrolls a loadable message of HELP-alphabet characters across N_DIGITS

---
 rtl/hex_scroll_display.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hex_scroll_display.sv
// hex_scroll_display: scrolls a circular message of HELP-alphabet characters
// across N_DIGITS active-low seven-segment digits (digit 0 = rightmost).
// Optional feature macro: SCROLL_DIR_EN adds the dir port (1 = scroll right).
module hex_scroll_display #(
    parameter int N_DIGITS = 4,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 50_000_000,
    localparam int PW = (MSG_LEN  > 1) ? $clog2(MSG_LEN)  : 1,
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    load,
    input  logic [3*MSG_LEN-1:0]    msg_in,
    input  logic                    run,
`ifdef SCROLL_DIR_EN
    input  logic                    dir,
`endif
    output logic [7*N_DIGITS-1:0]   hex_out,
    output logic                    step_tick,
    output logic [PW-1:0]           pos
);

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_SCROLL = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                    r_state;
    logic [3*MSG_LEN-1:0]      r_msg;
    logic [PW-1:0]             r_pos;
    logic [CW-1:0]             r_cnt;
    logic                      r_tick;
    logic [7*N_DIGITS-1:0]     r_hex;

    logic                      w_step_end;
    logic [PW-1:0]             w_pos_next;
    logic [7*N_DIGITS-1:0]     w_window;
    int unsigned               w_idx;

    // Character code to active-low segment pattern (bit 6 = g)
    function automatic logic [6:0] seg(input logic [2:0] code);
        case (code)
            3'd0:    seg = 7'b0001001; // H
            3'd1:    seg = 7'b0000110; // E
            3'd2:    seg = 7'b1000111; // L
            3'd3:    seg = 7'b0001100; // P
            default: seg = 7'b1111111; // blank
        endcase
    endfunction

    assign w_step_end = (r_cnt == CW'(TICK_DIV - 1));

    // Next window position on a scroll step, wrapping around the message
    always_comb begin
        w_pos_next = (r_pos == PW'(MSG_LEN - 1)) ? '0 : r_pos + 1'b1;
`ifdef SCROLL_DIR_EN
        if (dir) begin
            w_pos_next = (r_pos == '0) ? PW'(MSG_LEN - 1) : r_pos - 1'b1;
        end
`endif
    end

    // Window decode; pos + N_DIGITS-1 < 2*MSG_LEN, so one subtraction wraps it
    always_comb begin
        w_window = '1;
        w_idx    = 0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            w_idx = int'(r_pos) + N_DIGITS - 1 - k;
            if (w_idx >= MSG_LEN) begin
                w_idx = w_idx - MSG_LEN;
            end
            w_window[7*k +: 7] = seg(r_msg[3*w_idx +: 3]);
        end
    end

    // Control FSM with registered display, step pulse, position and prescaler
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_BLANK;
            r_msg   <= {MSG_LEN{3'd4}};
            r_pos   <= '0;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_hex   <= '1;
        end else begin
            r_tick <= 1'b0;
            r_hex  <= (r_state == S_BLANK) ? '1 : w_window;
            if (load) begin
                // load takes priority over any step falling on the same cycle
                r_msg   <= msg_in;
                r_pos   <= '0;
                r_cnt   <= '0;
                r_state <= run ? S_SCROLL : S_HOLD;
            end else begin
                case (r_state)
                    S_BLANK: begin
                        r_state <= S_BLANK;
                    end
                    S_SCROLL: begin
                        if (w_step_end) begin
                            r_cnt  <= '0;
                            r_tick <= 1'b1;
                            r_pos  <= w_pos_next;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (!run) begin
                            r_state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (run) begin
                            r_state <= S_SCROLL;
                        end
                    end
                    default: begin
                        r_state <= S_BLANK;
                    end
                endcase
            end
        end
    end

    assign hex_out   = r_hex;
    assign step_tick = r_tick;
    assign pos       = r_pos;

endmodule
